// File: rtl/register_file_pkg.sv
// Shared definitions for the register file: default geometry, the hardwired
// zero register index and the clear-sequencer state type.
// Imported by register_file and register_file_clear_sequencer.
package register_file_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 6;
  localparam int DEFAULT_NUM_REGS   = 32;

  // Register index that always reads as zero and ignores writes.
  localparam int ZERO_REGISTER = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clear_state_t;

endpackage

// File: rtl/register_file_clear_sequencer.sv
// Post-reset clear sequencer: walks entries 1..NUM_REGS-1 writing zero, then raises ready.
// Latency: NUM_REGS-1 posedges after reset release; ready is registered and rises after the last clear write.
// Backpressure: none; while clearing it owns the write path and port writes are ignored.
module register_file_clear_sequencer
  import register_file_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_REGS   = DEFAULT_NUM_REGS
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  clear_write_enable,
  output logic [ADDR_WIDTH-1:0] clear_write_address,
  output logic                  register_file_ready
);

  localparam logic [ADDR_WIDTH-1:0] FIRST_INDEX = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX  = ADDR_WIDTH'(NUM_REGS - 1);

  clear_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] clear_index_q, clear_index_d;
  logic                  ready_q, ready_d;

  // State, index and ready flag; reset restarts the clear from entry 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= CLEAR;
      clear_index_q <= FIRST_INDEX;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      clear_index_q <= clear_index_d;
      ready_q       <= ready_d;
    end
  end

  // Next state: one zero write per cycle in CLEAR, READY is terminal until reset.
  always_comb begin
    state_d            = state_q;
    clear_index_d      = clear_index_q;
    ready_d            = ready_q;
    clear_write_enable = 1'b0;
    case (state_q)
      CLEAR: begin
        clear_write_enable = 1'b1;
        if (clear_index_q == LAST_INDEX) begin
          state_d = READY;
          ready_d = 1'b1;
        end else begin
          clear_index_d = clear_index_q + FIRST_INDEX;
        end
      end
      READY: begin
        state_d = READY;
      end
    endcase
  end

  assign clear_write_address = clear_index_q;
  assign register_file_ready = ready_q;

endmodule

// File: rtl/register_file.sv
// Register file: 2 combinational read ports, 1 synchronous write port, r0 hardwired to zero, RAM-style storage.
// Latency: reads zero-cycle; writes visible next cycle (same cycle with REGISTER_FILE_BYPASS_EN defined).
// Backpressure: none; reads return 0 and port writes are dropped until the post-reset clear finishes (ready high).
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_REGS   = DEFAULT_NUM_REGS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] register_file_read_address_1,
  input  logic [ADDR_WIDTH-1:0] register_file_read_address_2,
  output logic [DATA_WIDTH-1:0] register_file_read_value_1,
  output logic [DATA_WIDTH-1:0] register_file_read_value_2,
  input  logic [ADDR_WIDTH-1:0] register_file_write_address,
  input  logic [DATA_WIDTH-1:0] register_file_write_value,
  input  logic                  register_file_write_enable,
  output logic                  register_file_ready
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // One extra bit so NUM_REGS == 2**ADDR_WIDTH still compares at full address width.
  localparam logic [ADDR_WIDTH:0]   NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR  = ADDR_WIDTH'(ZERO_REGISTER);

  // Plain array without reset so it can map onto RAM; zeroed by the sequencer.
  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

  logic                  clear_write_enable;
  logic [ADDR_WIDTH-1:0] clear_write_address;
  logic                  ready;

  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_dat;

  logic                  rd1_legal, rd2_legal, wr_legal;
  logic                  port_wr;

  register_file_clear_sequencer #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_REGS  (NUM_REGS)
  ) u_clear_sequencer (
    .clock              (clock),
    .reset              (reset),
    .clear_write_enable (clear_write_enable),
    .clear_write_address(clear_write_address),
    .register_file_ready(ready)
  );

  assign register_file_ready = ready;

  // An address names a real register only if nonzero and below NUM_REGS.
  assign rd1_legal = ({1'b0, register_file_read_address_1} < NUM_REGS_W) &&
                     (register_file_read_address_1 != ZERO_ADDR);
  assign rd2_legal = ({1'b0, register_file_read_address_2} < NUM_REGS_W) &&
                     (register_file_read_address_2 != ZERO_ADDR);
  assign wr_legal  = ({1'b0, register_file_write_address} < NUM_REGS_W) &&
                     (register_file_write_address != ZERO_ADDR);

  // A port write only lands once ready and only to a real register.
  assign port_wr = ready && register_file_write_enable && wr_legal;

  // Write-source mux: the clear sequencer has priority and writes zeros.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = '0;
    wr_dat = '0;
    if (clear_write_enable) begin
      wr_en  = 1'b1;
      wr_idx = clear_write_address[IDX_W-1:0];
    end else if (port_wr) begin
      wr_en  = 1'b1;
      wr_idx = register_file_write_address[IDX_W-1:0];
      wr_dat = register_file_write_value;
    end
  end

  // Storage update, one entry per cycle.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_dat;
    end
  end

  // Read ports: zero while clearing or for r0/out-of-range, optional same-cycle bypass.
  always_comb begin
    register_file_read_value_1 = '0;
    register_file_read_value_2 = '0;
    if (ready && rd1_legal) begin
      register_file_read_value_1 = mem_q[register_file_read_address_1[IDX_W-1:0]];
    end
    if (ready && rd2_legal) begin
      register_file_read_value_2 = mem_q[register_file_read_address_2[IDX_W-1:0]];
    end
`ifdef REGISTER_FILE_BYPASS_EN
    if (port_wr && (register_file_write_address == register_file_read_address_1)) begin
      register_file_read_value_1 = register_file_write_value;
    end
    if (port_wr && (register_file_write_address == register_file_read_address_2)) begin
      register_file_read_value_2 = register_file_write_value;
    end
`endif
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: clear timing, directed vector table,
// randomized traffic against a reference model, and reset-mid-clear.
module tb_register_file;

  localparam int NREGS = 32;
`ifdef REGISTER_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  ra1 = '0, ra2 = '0, wa = '0;
  logic [31:0] rv1, rv2, wv = '0;
  logic        we = 1'b0;
  logic        ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [NREGS];

  typedef struct {
    logic        we;
    logic [5:0]  wa;
    logic [31:0] wv;
    logic [5:0]  ra1;
    logic [5:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [11];

  register_file dut (
    .clock                        (clock),
    .reset                        (reset),
    .register_file_read_address_1 (ra1),
    .register_file_read_address_2 (ra2),
    .register_file_read_value_1   (rv1),
    .register_file_read_value_2   (rv2),
    .register_file_write_address  (wa),
    .register_file_write_value    (wv),
    .register_file_write_enable   (we),
    .register_file_ready          (ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input int ra, input bit w_en, input int w_a,
                                             input logic [31:0] w_v);
    if (ra == 0 || ra >= NREGS) return 32'h0;
    if (BYP && w_en && w_a == ra) return w_v;
    return model[ra];
  endfunction

  task automatic model_write(input bit w_en, input int w_a, input logic [31:0] w_v);
    if (w_en && w_a != 0 && w_a < NREGS) model[w_a] = w_v;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // After reset release, ready must be low for 30 edges and high after edge 31.
  task automatic check_clear_window(input string tag);
    for (int k = 1; k <= NREGS - 1; k++) begin
      step();
      check({tag, "_ready"}, {31'h0, ready}, {31'h0, (k == NREGS - 1)});
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 6'd5,  32'hDEADBEEF, 6'd5,  6'd0,  BYP ? 32'hDEADBEEF : 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 6'd0,  32'h0,        6'd5,  6'd0,  32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b1, 6'd0,  32'h12345678, 6'd0,  6'd8,  32'h0, 32'h0};
    vecs[3]  = '{1'b1, 6'd40, 32'hFFFFFFFF, 6'd40, 6'd8,  32'h0, 32'h0};
    vecs[4]  = '{1'b0, 6'd0,  32'h0,        6'd0,  6'd40, 32'h0, 32'h0};
    vecs[5]  = '{1'b0, 6'd0,  32'h0,        6'd8,  6'd5,  32'h0, 32'hDEADBEEF};
    vecs[6]  = '{1'b1, 6'd7,  32'hA5A5A5A5, 6'd7,  6'd7,
                 BYP ? 32'hA5A5A5A5 : 32'h0, BYP ? 32'hA5A5A5A5 : 32'h0};
    vecs[7]  = '{1'b0, 6'd0,  32'h0,        6'd7,  6'd7,  32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[8]  = '{1'b1, 6'd9,  32'h00000055, 6'd9,  6'd5,  BYP ? 32'h55 : 32'h0, 32'hDEADBEEF};
    vecs[9]  = '{1'b1, 6'd63, 32'h00000001, 6'd63, 6'd31, 32'h0, 32'h0};
    vecs[10] = '{1'b0, 6'd0,  32'h0,        6'd31, 6'd9,  32'h0, 32'h55};

    model_clear();

    // Reset state.
    ra1 = 6'd3; ra2 = 6'd1;
    step();
    step();
    check("reset_ready", {31'h0, ready}, 32'h0);
    check("reset_rd1", rv1, 32'h0);
    check("reset_rd2", rv2, 32'h0);
    reset = 1'b1;

    // First clear; port writes to r3 in the middle must be ignored.
    for (int k = 1; k <= NREGS - 1; k++) begin
      step();
      check("clear1_ready", {31'h0, ready}, {31'h0, (k == NREGS - 1)});
      if (k == 5) begin we = 1'b1; wa = 6'd3; wv = 32'h1; end
      if (k == 10) check("clear_rd_zero", rv1, 32'h0);
      if (k == 11) we = 1'b0;
    end

    // Every register reads zero after the clear.
    for (int r = 1; r < NREGS; r++) begin
      ra1 = 6'(r); ra2 = 6'(NREGS - r);
      #1;
      check("post_clear_rd1", rv1, 32'h0);
      check("post_clear_rd2", rv2, 32'h0);
    end

    // Directed vectors, one cycle each.
    for (int i = 0; i < 11; i++) begin
      step();
      we = vecs[i].we; wa = vecs[i].wa; wv = vecs[i].wv;
      ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
      #4;
      check($sformatf("vec%0d_rd1", i), rv1, vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), rv2, vecs[i].e2);
      model_write(vecs[i].we, int'(vecs[i].wa), vecs[i].wv);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step();
      we = 1'($urandom_range(0, 1));
      wa = 6'($urandom_range(0, 63));
      wv = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 6'($urandom_range(0, 63));
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 6'($urandom_range(0, 63));
      #4;
      check("rand_rd1", rv1, model_read(int'(ra1), we, int'(wa), wv));
      check("rand_rd2", rv2, model_read(int'(ra2), we, int'(wa), wv));
      model_write(we, int'(wa), wv);
    end

    // Write r9, then reset from READY and again mid-clear.
    step();
    we = 1'b1; wa = 6'd9; wv = 32'h55;
    step();
    we = 1'b0;
    ra1 = 6'd9; ra2 = 6'd5;
    #4;
    check("r9_written", rv1, 32'h55);
    step();
    reset = 1'b0;
    model_clear();
    step();
    check("reready_ready", {31'h0, ready}, 32'h0);
    check("reready_rd", rv1, 32'h0);
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 10) check("midclear_ready", {31'h0, ready}, 32'h0);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_clear_window("reclear");
    ra1 = 6'd9; ra2 = 6'd7;
    #4;
    check("r9_cleared", rv1, 32'h0);
    check("r7_cleared", rv2, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
